// File: rtl/gray_step_sequencer_if.sv
// Handshake and control bundle for the Gray step sequencer.
// master drives controls and g_ready; slave presents the Gray position.
interface gray_step_sequencer_if #(
   parameter int WIDTH = 2,
   parameter int DIV_W = 8
);
   logic             start;
   logic             stop;
   logic             step_req;
   logic             dir;
   logic [DIV_W-1:0] period;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] g_out;
   logic             g_valid;
   logic             g_ready;
   logic             busy;
   logic             wrap;

   modport master (
      output start, stop, step_req, dir, period,
      output load, load_val, g_ready,
      input  g_out, g_valid, busy, wrap
   );

   modport slave (
      input  start, stop, step_req, dir, period,
      input  load, load_val, g_ready,
      output g_out, g_valid, busy, wrap
   );
endinterface

// File: rtl/gray_step_sequencer.sv
// Binary position stepper that presents its Gray-coded value
// over a valid/ready handshake, single-step or free-running.
module gray_step_sequencer #(
   parameter int WIDTH = 2,
   parameter int DIV_W = 8
) (
   input logic                 clk,
   input logic                 rst,
   gray_step_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PRESENT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] g_q;
   logic             valid_q;
   logic             busy_q;
   logic             wrap_q;
   logic             run;
   logic [DIV_W-1:0] timer;

   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gray_nxt;
   logic [WIDTH-1:0] gray_load;
   logic             wrap_nxt;
   logic [DIV_W-1:0] reload;

   always_comb begin
      bin_nxt   = bus.dir ? bin + 1'b1 : bin - 1'b1;
      gray_nxt  = bin_nxt ^ (bin_nxt >> 1);
      gray_load = bus.load_val ^ (bus.load_val >> 1);
      wrap_nxt  = bus.dir ? (&bin) : ~(|bin);
      reload    = (bus.period == '0) ? DIV_W'(1) : bus.period;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         bin     <= '0;
         g_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         wrap_q  <= 1'b0;
         run     <= 1'b0;
         timer   <= '0;
      end else begin
         wrap_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.load) begin
                  bin <= bus.load_val;
                  g_q <= gray_load;
               end else if (bus.start) begin
                  run    <= 1'b1;
                  timer  <= reload;
                  busy_q <= 1'b1;
                  state  <= S_WAIT;
               end else if (bus.step_req) begin
                  bin     <= bin_nxt;
                  g_q     <= gray_nxt;
                  wrap_q  <= wrap_nxt;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= S_PRESENT;
               end
            end
            S_WAIT: begin
               // stop wins over an expiring interval
               if (bus.stop) begin
                  run    <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else if (timer <= DIV_W'(1)) begin
                  bin     <= bin_nxt;
                  g_q     <= gray_nxt;
                  wrap_q  <= wrap_nxt;
                  valid_q <= 1'b1;
                  state   <= S_PRESENT;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_PRESENT: begin
               if (bus.stop) run <= 1'b0;
               if (bus.g_ready) begin
                  valid_q <= 1'b0;
                  if (run && !bus.stop) begin
                     timer <= reload;
                     state <= S_WAIT;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.g_out   = g_q;
   assign bus.g_valid = valid_q;
   assign bus.busy    = busy_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Randomised and directed bench for gray_step_sequencer against
// a cycle-level behavioural model of the stepping rules.
module tb_gray_step_sequencer;

   localparam int WIDTH = 2;
   localparam int DIV_W = 8;
   localparam int N = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gray_step_sequencer_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

   gray_step_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // model: 0 idle, 1 counting down to an advance, 2 holding a code
   int m_phase;
   int m_pos;
   int m_left;
   bit m_run;
   bit m_wrap;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pos   = 0;
      m_left  = 0;
      m_run   = 0;
      m_wrap  = 0;
   endtask

   task automatic model_advance();
      if (bus.dir) begin
         m_wrap = (m_pos == N - 1);
         m_pos  = (m_pos + 1) % N;
      end else begin
         m_wrap = (m_pos == 0);
         m_pos  = (m_pos + N - 1) % N;
      end
      m_phase = 2;
   endtask

   task automatic model_step();
      int p;
      p = (bus.period == 0) ? 1 : int'(bus.period);
      m_wrap = 0;
      case (m_phase)
         0: begin
            if (bus.load) m_pos = int'(bus.load_val);
            else if (bus.start) begin
               m_run = 1; m_left = p; m_phase = 1;
            end else if (bus.step_req) model_advance();
         end
         1: begin
            if (bus.stop) begin
               m_run = 0; m_phase = 0;
            end else if (m_left == 1) model_advance();
            else m_left--;
         end
         default: begin
            if (bus.stop) m_run = 0;
            if (bus.g_ready) begin
               if (m_run) begin
                  m_left = p; m_phase = 1;
               end else m_phase = 0;
            end
         end
      endcase
   endtask

   task automatic compare();
      chk("g_out", int'(bus.g_out), gray(m_pos));
      chk("g_valid", int'(bus.g_valid), int'(m_phase == 2));
      chk("busy", int'(bus.busy), int'(m_phase != 0));
      chk("wrap", int'(bus.wrap), int'(m_wrap));
   endtask

   // one clock: DUT and model both consume current inputs, then compare
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic quiet();
      bus.start    = 0;
      bus.stop     = 0;
      bus.step_req = 0;
      bus.load     = 0;
   endtask

   int last_v;
   int gap_ok;
   int held;
   int n;

   initial begin
      quiet();
      bus.dir      = 1;
      bus.period   = '0;
      bus.load_val = '0;
      bus.g_ready  = 1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      compare();

      // single steps up through the wrap
      for (int i = 0; i < 4; i++) begin
         bus.step_req = 1;
         cycle();
         bus.step_req = 0;
         chk("step_up_valid", int'(bus.g_valid), 1);
         case (i)
            0: chk("step_up_g", int'(bus.g_out), 1);
            1: chk("step_up_g", int'(bus.g_out), 3);
            2: chk("step_up_g", int'(bus.g_out), 2);
            default: chk("step_up_g", int'(bus.g_out), 0);
         endcase
         chk("step_up_wrap", int'(bus.wrap), (i == 3) ? 1 : 0);
         cycle();
         chk("step_up_drop", int'(bus.g_valid), 0);
      end

      // step down from zero wraps to all-ones
      bus.dir = 0;
      bus.step_req = 1;
      cycle();
      bus.step_req = 0;
      chk("down_g", int'(bus.g_out), 2);
      chk("down_wrap", int'(bus.wrap), 1);
      cycle();

      // free run, period 3 then 0
      bus.dir = 1;
      bus.period = 8'd3;
      bus.start = 1;
      cycle();
      bus.start = 0;
      last_v = -1;
      gap_ok = 1;
      for (int c = 0; c < 14; c++) begin
         cycle();
         if (bus.g_valid) begin
            if (last_v >= 0 && c - last_v != 4) gap_ok = 0;
            last_v = c;
         end
      end
      chk("cadence_p3", gap_ok, 1);
      bus.period = 8'd0;
      for (int c = 0; c < 6; c++) cycle();
      last_v = -1;
      gap_ok = 1;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (bus.g_valid) begin
            if (last_v >= 0 && c - last_v != 2) gap_ok = 0;
            last_v = c;
         end
      end
      chk("cadence_p0", gap_ok, 1);
      bus.stop = 1;
      cycle();
      bus.stop = 0;
      chk("stop_idle", int'(bus.busy), 0);

      // stalled consumer with stop pending
      bus.period = 8'd1;
      bus.g_ready = 0;
      bus.start = 1;
      cycle();
      bus.start = 0;
      n = 0;
      while (!bus.g_valid && n < 10) begin
         cycle();
         n++;
      end
      chk("stall_reach", int'(bus.g_valid), 1);
      held = int'(bus.g_out);
      bus.stop = 1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("stall_hold", int'(bus.g_valid), 1);
         chk("stall_g", int'(bus.g_out), held);
      end
      bus.stop = 0;
      bus.g_ready = 1;
      cycle();
      chk("stall_done", int'(bus.busy), 0);

      // load in idle, then ignored while presenting
      bus.load = 1;
      bus.load_val = 2'd2;
      cycle();
      bus.load = 0;
      chk("load_g", int'(bus.g_out), 3);
      chk("load_valid", int'(bus.g_valid), 0);
      bus.g_ready = 0;
      bus.step_req = 1;
      cycle();
      bus.step_req = 0;
      held = int'(bus.g_out);
      bus.load = 1;
      bus.load_val = 2'd0;
      cycle();
      bus.load = 0;
      chk("load_ignored", int'(bus.g_out), held);

      // asynchronous reset mid-clock with a code pending
      #2 rst = 1;
      #1;
      chk("rst_g", int'(bus.g_out), 0);
      chk("rst_valid", int'(bus.g_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_wrap", int'(bus.wrap), 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      bus.g_ready = 1;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.start    = ($urandom_range(0, 9) == 0);
         bus.stop     = ($urandom_range(0, 19) == 0);
         bus.step_req = ($urandom_range(0, 5) == 0);
         bus.load     = ($urandom_range(0, 15) == 0);
         bus.load_val = WIDTH'($urandom);
         bus.period   = DIV_W'($urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
         bus.g_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      quiet();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
